// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types and constants for the ALU issue arbiter.
package alu_issue_arbiter_pkg;

   localparam int unsigned NUM_THREADS_DEF = 4;
   localparam int unsigned NUM_ALUS_DEF    = 2;
   localparam int unsigned OH_W            = 7;
   localparam int unsigned XLEN            = 32;
   localparam int unsigned RA_W            = 5;

   localparam logic [OH_W-1:0] OH_NOP = 7'd0;

   // One decoded op, used both for thread requests and for ALU slots
   typedef struct packed {
      logic [OH_W-1:0] oh;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] ins;
      logic [XLEN-1:0] ins_addr;
      logic [RA_W-1:0] rd_addr;
      logic            rd_wen;
   } issue_op_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_picker.sv
// Rotating-priority picker: maps candidates, scanned from rr_ptr, onto free ALUs in index order.
module alu_issue_arbiter_rr_picker #(
   parameter int unsigned NT    = 4,
   parameter int unsigned NA    = 2,
   parameter int unsigned TID_W = 2
) (
   input  logic [NT-1:0]            req,
   input  logic [TID_W-1:0]         rr_ptr,
   input  logic [NA-1:0]            free,
   output logic [NA-1:0][TID_W-1:0] grant_tid,
   output logic [NA-1:0]            grant_valid,
   output logic [NT-1:0]            granted,
   output logic                     any_grant,
   output logic [TID_W-1:0]         last_tid
);

   logic [NA-1:0]    remaining;
   logic [TID_W-1:0] t;
   logic             placed;

   always_comb begin
      grant_tid   = '0;
      grant_valid = '0;
      granted     = '0;
      any_grant   = 1'b0;
      last_tid    = '0;
      remaining   = free;
      t           = '0;
      placed      = 1'b0;
      for (int i = 0; i < int'(NT); i++) begin
         t      = rr_ptr + TID_W'(i);
         placed = 1'b0;
         // Each candidate takes the lowest-index ALU still unclaimed
         for (int k = 0; k < int'(NA); k++) begin
            if (req[t] && remaining[k] && !placed) begin
               grant_valid[k] = 1'b1;
               grant_tid[k]   = t;
               remaining[k]   = 1'b0;
               placed         = 1'b1;
               granted[t]     = 1'b1;
               any_grant      = 1'b1;
               last_tid       = t;
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Issues up to NUM_ALUS decoded ops per cycle from NUM_THREADS threads into registered ALU slots.
module alu_issue_arbiter
   import alu_issue_arbiter_pkg::*;
#(
   parameter int unsigned NUM_THREADS = NUM_THREADS_DEF,
   parameter int unsigned NUM_ALUS    = NUM_ALUS_DEF,
   parameter int unsigned TID_W       = $clog2(NUM_THREADS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_THREADS-1:0]              req_valid,
   output logic [NUM_THREADS-1:0]              req_ready,
   input  logic [NUM_THREADS-1:0][OH_W-1:0]    req_oh,
   input  logic [NUM_THREADS-1:0][XLEN-1:0]    req_op1,
   input  logic [NUM_THREADS-1:0][XLEN-1:0]    req_op2,
   input  logic [NUM_THREADS-1:0][XLEN-1:0]    req_ins,
   input  logic [NUM_THREADS-1:0][XLEN-1:0]    req_ins_addr,
   input  logic [NUM_THREADS-1:0][RA_W-1:0]    req_rd_addr,
   input  logic [NUM_THREADS-1:0]              req_rd_wen,
   input  logic [NUM_THREADS-1:0]              flush,
   input  logic [NUM_ALUS-1:0]                 alu_stall,
   output logic [NUM_ALUS-1:0]                 alu_valid,
   output logic [NUM_ALUS-1:0][TID_W-1:0]      alu_tid,
   output logic [NUM_ALUS-1:0][OH_W-1:0]       alu_oh,
   output logic [NUM_ALUS-1:0][XLEN-1:0]       alu_op1,
   output logic [NUM_ALUS-1:0][XLEN-1:0]       alu_op2,
   output logic [NUM_ALUS-1:0][XLEN-1:0]       alu_ins,
   output logic [NUM_ALUS-1:0][XLEN-1:0]       alu_ins_addr,
   output logic [NUM_ALUS-1:0][RA_W-1:0]       alu_rd_addr,
   output logic [NUM_ALUS-1:0]                 alu_rd_wen
);

   issue_op_t [NUM_THREADS-1:0]         req_op;
   logic      [NUM_THREADS-1:0]         nop;
   logic      [NUM_THREADS-1:0]         cand;
   logic      [NUM_THREADS-1:0]         granted;
   logic      [NUM_ALUS-1:0][TID_W-1:0] grant_tid;
   logic      [NUM_ALUS-1:0]            grant_valid;
   logic                                any_grant;
   logic      [TID_W-1:0]               last_tid;
   logic      [TID_W-1:0]               rr_ptr;

   issue_op_t [NUM_ALUS-1:0]            slot_q;
   logic      [NUM_ALUS-1:0]            valid_q;
   logic      [NUM_ALUS-1:0][TID_W-1:0] tid_q;

   // Gather per-thread request fields and classify candidates
   always_comb begin
      req_op = '0;
      nop    = '0;
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
         req_op[t].oh       = req_oh[t];
         req_op[t].op1      = req_op1[t];
         req_op[t].op2      = req_op2[t];
         req_op[t].ins      = req_ins[t];
         req_op[t].ins_addr = req_ins_addr[t];
         req_op[t].rd_addr  = req_rd_addr[t];
         req_op[t].rd_wen   = req_rd_wen[t];
         nop[t]             = (req_oh[t] == OH_NOP);
      end
   end

   assign cand = req_valid & ~flush & ~nop;

   alu_issue_arbiter_rr_picker #(
      .NT    (NUM_THREADS),
      .NA    (NUM_ALUS),
      .TID_W (TID_W)
   ) u_picker (
      .req         (cand),
      .rr_ptr      (rr_ptr),
      .free        (~alu_stall),
      .grant_tid   (grant_tid),
      .grant_valid (grant_valid),
      .granted     (granted),
      .any_grant   (any_grant),
      .last_tid    (last_tid)
   );

   // Consumed ops: granted, or dropped as NOP / flushed; never depends on slot state
   assign req_ready = granted | (req_valid & (flush | nop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= last_tid + TID_W'(1);
      end
   end

   // Free slots reload (or empty); stalled slots hold unless their thread is flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         valid_q <= '0;
         tid_q   <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_ALUS); k++) begin
            if (!alu_stall[k]) begin
               valid_q[k] <= grant_valid[k];
               if (grant_valid[k]) begin
                  tid_q[k]  <= grant_tid[k];
                  slot_q[k] <= req_op[grant_tid[k]];
               end
            end else if (valid_q[k] && flush[tid_q[k]]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      alu_valid = valid_q;
      alu_tid   = tid_q;
      for (int k = 0; k < int'(NUM_ALUS); k++) begin
         alu_oh[k]       = slot_q[k].oh;
         alu_op1[k]      = slot_q[k].op1;
         alu_op2[k]      = slot_q[k].op2;
         alu_ins[k]      = slot_q[k].ins;
         alu_ins_addr[k] = slot_q[k].ins_addr;
         alu_rd_addr[k]  = slot_q[k].rd_addr;
         alu_rd_wen[k]   = slot_q[k].rd_wen;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: a 2-ALU instance plus a 1-ALU instance sharing request inputs.
module tb_alu_issue_arbiter;

   localparam int unsigned NT = 4;
   localparam int unsigned NA = 2;
   localparam int unsigned TW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic rst1_n;

   logic [NT-1:0]       req_valid;
   logic [NT-1:0][6:0]  req_oh;
   logic [NT-1:0][31:0] req_op1, req_op2, req_ins, req_ins_addr;
   logic [NT-1:0][4:0]  req_rd_addr;
   logic [NT-1:0]       req_rd_wen;
   logic [NT-1:0]       flush;

   logic [NA-1:0]          alu_stall;
   logic [NT-1:0]          req_ready;
   logic [NA-1:0]          alu_valid;
   logic [NA-1:0][TW-1:0]  alu_tid;
   logic [NA-1:0][6:0]     alu_oh;
   logic [NA-1:0][31:0]    alu_op1, alu_op2, alu_ins, alu_ins_addr;
   logic [NA-1:0][4:0]     alu_rd_addr;
   logic [NA-1:0]          alu_rd_wen;

   logic [0:0]             stall1;
   logic [NT-1:0]          ready1;
   logic [0:0]             valid1;
   logic [0:0][TW-1:0]     tid1;
   logic [0:0][6:0]        oh1;
   logic [0:0][31:0]       op1_1, op2_1, ins1, ins_addr1;
   logic [0:0][4:0]        rd_addr1;
   logic [0:0]             rd_wen1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.NUM_THREADS(NT), .NUM_ALUS(NA)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_oh(req_oh),
      .req_op1(req_op1), .req_op2(req_op2), .req_ins(req_ins), .req_ins_addr(req_ins_addr),
      .req_rd_addr(req_rd_addr), .req_rd_wen(req_rd_wen), .flush(flush),
      .alu_stall(alu_stall), .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_oh(alu_oh),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ins(alu_ins), .alu_ins_addr(alu_ins_addr),
      .alu_rd_addr(alu_rd_addr), .alu_rd_wen(alu_rd_wen)
   );

   alu_issue_arbiter #(.NUM_THREADS(NT), .NUM_ALUS(1)) dut1 (
      .clk(clk), .rst_n(rst1_n),
      .req_valid(req_valid), .req_ready(ready1), .req_oh(req_oh),
      .req_op1(req_op1), .req_op2(req_op2), .req_ins(req_ins), .req_ins_addr(req_ins_addr),
      .req_rd_addr(req_rd_addr), .req_rd_wen(req_rd_wen), .flush(flush),
      .alu_stall(stall1), .alu_valid(valid1), .alu_tid(tid1), .alu_oh(oh1),
      .alu_op1(op1_1), .alu_op2(op2_1), .alu_ins(ins1), .alu_ins_addr(ins_addr1),
      .alu_rd_addr(rd_addr1), .alu_rd_wen(rd_wen1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_ops();
      for (int t = 0; t < int'(NT); t++) begin
         req_oh[t]       = 7'(t + 1);
         req_op1[t]      = 32'h100 + 32'(t);
         req_op2[t]      = 32'h200 + 32'(t);
         req_ins[t]      = 32'hA000_0000 + 32'(t);
         req_ins_addr[t] = 32'h1000 + 32'(4 * t);
         req_rd_addr[t]  = 5'(t + 1);
         req_rd_wen[t]   = 1'b1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rst1_n    = 1'b0;
      req_valid = '0;
      flush     = '0;
      alu_stall = '0;
      stall1    = '0;
      init_ops();
      repeat (2) tick();
      chk("reset_valid", 64'(alu_valid), 64'h0);
      chk("reset_tid", 64'(alu_tid), 64'h0);
      chk("reset_op1", 64'(alu_op1), 64'h0);
      chk("reset_valid1", 64'(valid1), 64'h0);

      // All four threads requesting: pairs (0,1),(2,3),(0,1)
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      #1 chk("rr_ready_a", 64'(req_ready), 64'b0011);
      tick();
      chk("rr_valid_a", 64'(alu_valid), 64'b11);
      chk("rr_tid0_a", 64'(alu_tid[0]), 64'd0);
      chk("rr_tid1_a", 64'(alu_tid[1]), 64'd1);
      chk("rr_op1_0", 64'(alu_op1[0]), 64'h100);
      chk("rr_op1_1", 64'(alu_op1[1]), 64'h101);
      chk("rr_addr_1", 64'(alu_ins_addr[1]), 64'h1004);
      chk("rr_ready_b", 64'(req_ready), 64'b1100);
      tick();
      chk("rr_tid0_b", 64'(alu_tid[0]), 64'd2);
      chk("rr_tid1_b", 64'(alu_tid[1]), 64'd3);
      chk("rr_ready_c", 64'(req_ready), 64'b0011);
      tick();
      chk("rr_tid0_c", 64'(alu_tid[0]), 64'd0);
      chk("rr_tid1_c", 64'(alu_tid[1]), 64'd1);

      // Asynchronous reset with both slots occupied
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(alu_valid), 64'h0);
      chk("mid_rst_tid", 64'(alu_tid), 64'h0);
      chk("mid_rst_op1", 64'(alu_op1), 64'h0);
      #2 rst_n = 1'b1;
      #1 chk("post_rst_ready", 64'(req_ready), 64'b0011);
      tick();
      chk("post_rst_tid0", 64'(alu_tid[0]), 64'd0);
      chk("post_rst_tid1", 64'(alu_tid[1]), 64'd1);

      // Lone T0 from rr_ptr=2 moves the pointer to 1
      req_valid = 4'b0001;
      #1 chk("solo_ready", 64'(req_ready), 64'b0001);
      tick();
      chk("solo_valid", 64'(alu_valid), 64'b01);
      chk("solo_tid0", 64'(alu_tid[0]), 64'd0);

      // ALU0 stalled: T1 goes to ALU1, slot 0 holds T0
      alu_stall = 2'b01;
      req_valid = 4'b0110;
      #1 chk("stall_ready", 64'(req_ready), 64'b0010);
      tick();
      chk("stall_valid", 64'(alu_valid), 64'b11);
      chk("stall_tid1", 64'(alu_tid[1]), 64'd1);
      chk("stall_op1_1", 64'(alu_op1[1]), 64'h101);
      chk("hold_tid0", 64'(alu_tid[0]), 64'd0);
      chk("hold_op1_0", 64'(alu_op1[0]), 64'h100);
      chk("hold_op2_0", 64'(alu_op2[0]), 64'h200);
      chk("hold_ins_0", 64'(alu_ins[0]), 64'hA000_0000);

      // rr_ptr now 2: T2 outranks T1
      alu_stall = 2'b00;
      #1 chk("ptr2_ready", 64'(req_ready), 64'b0110);
      tick();
      chk("ptr2_tid0", 64'(alu_tid[0]), 64'd2);
      chk("ptr2_tid1", 64'(alu_tid[1]), 64'd1);
      chk("ptr2_valid", 64'(alu_valid), 64'b11);

      // NOP on T2 dropped, ADD on T3 issued
      req_valid  = 4'b1100;
      req_oh[2]  = 7'd0;
      req_oh[3]  = 7'd28;
      req_op1[3] = 32'd5;
      req_op2[3] = 32'd7;
      #1 chk("nop_ready", 64'(req_ready), 64'b1100);
      tick();
      chk("nop_valid", 64'(alu_valid), 64'b01);
      chk("nop_tid0", 64'(alu_tid[0]), 64'd3);
      chk("nop_oh0", 64'(alu_oh[0]), 64'd28);
      chk("nop_op1_0", 64'(alu_op1[0]), 64'd5);
      chk("nop_op2_0", 64'(alu_op2[0]), 64'd7);

      // T1 into slot 0, then flushed while stalled
      init_ops();
      req_valid = 4'b0010;
      #1 chk("fl_load_ready", 64'(req_ready), 64'b0010);
      tick();
      chk("fl_load_valid", 64'(alu_valid), 64'b01);
      chk("fl_load_tid0", 64'(alu_tid[0]), 64'd1);
      alu_stall = 2'b01;
      flush     = 4'b0010;
      #1 chk("fl_ready", 64'(req_ready), 64'b0010);
      tick();
      chk("fl_valid", 64'(alu_valid), 64'b00);
      chk("fl_tid0_held", 64'(alu_tid[0]), 64'd1);

      // Everything stalled: only the NOP drop is acknowledged
      flush     = 4'b0000;
      alu_stall = 2'b11;
      req_valid = 4'b1111;
      req_oh[0] = 7'd0;
      #1 chk("allstall_ready", 64'(req_ready), 64'b0001);
      tick();
      chk("allstall_valid", 64'(alu_valid), 64'b00);
      alu_stall = 2'b00;
      req_oh[0] = 7'd1;
      #1 chk("resume_ready", 64'(req_ready), 64'b1100);
      tick();
      chk("resume_tid0", 64'(alu_tid[0]), 64'd2);
      chk("resume_tid1", 64'(alu_tid[1]), 64'd3);
      chk("resume_valid", 64'(alu_valid), 64'b11);

      // Single-ALU instance: strict 0,1,2,3,0,1,2,3 rotation
      rst1_n = 1'b1;
      #1 chk("one_ready", 64'(ready1), 64'b0001);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("one_valid_%0d", i), 64'(valid1), 64'd1);
         chk($sformatf("one_tid_%0d", i), 64'(tid1[0]), 64'(i % 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
